// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rst_seq_pkg;

  localparam int DEF_NUM_STAGES   = 3;
  localparam int DEF_STAGE_DLY    = 16;
  localparam int DEF_SOFT_HOLD    = 8;
  localparam int DEF_WDOG_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    RELEASE = 2'd0,
    RUN     = 2'd1,
    SOFT    = 2'd2
  } state_t;

  // One spare bit above the largest terminal count so no counter can wrap.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Clearable up-counter with an equality compare against a terminal value.
// Latency: count registered; tc is a compare on the registered count.
// Backpressure: none; the caller gates en to hold or saturate.
module rst_seq_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  // Clear wins over count; hard reset behaves like a clear.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/rst_seq.sv
// Staged reset sequencer: releases stage_rst_n bits one at a time; soft request reruns it.
// Latency: stage k releases STAGE_DLY*(k+1) edges after reset exit; all outputs registered.
// Backpressure: none. Optional watchdog under RST_SEQ_WDOG_EN.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES   = DEF_NUM_STAGES,
  parameter int STAGE_DLY    = DEF_STAGE_DLY,
  parameter int SOFT_HOLD    = DEF_SOFT_HOLD,
  parameter int WDOG_TIMEOUT = DEF_WDOG_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  soft_rst_req,
`ifdef RST_SEQ_WDOG_EN
  input  logic                  wdog_kick,
  output logic                  wdog_fired,
`endif
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  rst_done,
  output logic                  busy
);

  localparam int CW = cnt_width(STAGE_DLY, SOFT_HOLD, WDOG_TIMEOUT);
  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CW-1:0] REL_TC = CW'(STAGE_DLY - 1);
  // The edge that enters SOFT counts as the first hold cycle, so the exit
  // compare sits one below SOFT_HOLD-1 (a hold of 1 still needs one edge).
  localparam logic [CW-1:0] SOFT_TC  = CW'((SOFT_HOLD >= 2) ? SOFT_HOLD - 2 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_STAGES - 1);

  if (NUM_STAGES < 1 || STAGE_DLY < 1 || SOFT_HOLD < 1) begin : g_bad_param
    $error("rst_seq: NUM_STAGES, STAGE_DLY and SOFT_HOLD must all be >= 1");
  end

  state_t                  state, state_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic                    started;
  logic [NUM_STAGES-1:0]   stage_nxt;
  logic                    done_nxt;
  logic                    cnt_clr, cnt_en, cnt_tc;
  logic [CW-1:0]           tc_val;
  logic                    soft_evt, go_soft, rel_fire;

  assign tc_val = (state == SOFT) ? SOFT_TC : REL_TC;

  rst_seq_cnt #(.W(CW)) u_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .tc_val (tc_val),
    .tc     (cnt_tc)
  );

`ifdef RST_SEQ_WDOG_EN
  localparam logic [CW-1:0] WD_TC = CW'(WDOG_TIMEOUT - 1);
  logic wd_tc, wd_to;

  rst_seq_cnt #(.W(CW)) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    ((state != RUN) || wdog_kick),
    .en     (1'b1),
    .tc_val (WD_TC),
    .tc     (wd_tc)
  );

  // A kick on the timeout cycle suppresses the timeout.
  assign wd_to    = (state == RUN) && wd_tc && !wdog_kick;
  assign soft_evt = soft_rst_req || wd_to;

  // Sticky timeout flag, cleared only by hard reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_fired <= 1'b0;
    end else if (wd_to) begin
      wdog_fired <= 1'b1;
    end
  end
`else
  assign soft_evt = soft_rst_req;
`endif

  // Requests in SOFT only matter through the exit condition.
  assign go_soft  = (state != SOFT) && soft_evt;
  // started holds off counting on the first edge after hard reset exits.
  assign rel_fire = (state == RELEASE) && !soft_evt && started && cnt_tc;

  // State register plus registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RELEASE;
      idx         <= '0;
      started     <= 1'b0;
      stage_rst_n <= '0;
      rst_done    <= 1'b0;
      busy        <= 1'b1;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      started     <= 1'b1;
      stage_rst_n <= stage_nxt;
      rst_done    <= done_nxt;
      busy        <= (state_nxt != RUN);
    end
  end

  // Next-state, stage index and delay-counter control.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    unique case (state)
      RELEASE: begin
        if (go_soft) begin
          state_nxt = SOFT;
          cnt_clr   = 1'b1;
        end else if (rel_fire) begin
          cnt_clr = 1'b1;
          if (idx == LAST_IDX) begin
            state_nxt = RUN;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else if (started) begin
          cnt_en = 1'b1;
        end
      end
      RUN: begin
        if (go_soft) begin
          state_nxt = SOFT;
          cnt_clr   = 1'b1;
        end
      end
      SOFT: begin
        if (cnt_tc && !soft_rst_req) begin
          state_nxt = RELEASE;
          idx_nxt   = '0;
          cnt_clr   = 1'b1;
        end else if (!cnt_tc) begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_nxt = RELEASE;
        idx_nxt   = '0;
        cnt_clr   = 1'b1;
      end
    endcase
  end

  // Next values of the stage resets and rst_done; releases accumulate.
  always_comb begin
    stage_nxt = stage_rst_n;
    done_nxt  = rst_done;
    if (go_soft) begin
      stage_nxt = '0;
      done_nxt  = 1'b0;
    end else if (rel_fire) begin
      stage_nxt[idx] = 1'b1;
      if (idx == LAST_IDX) begin
        done_nxt = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with default stage timing.
// Edge numbering: e=0 is the first posedge sampling rst_n=1; outputs sampled 1ns after each edge.
// Watchdog scenarios are compiled in only with RST_SEQ_WDOG_EN.
module tb_rst_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic [2:0] stage_rst_n;
  logic       rst_done;
  logic       busy;
`ifdef RST_SEQ_WDOG_EN
  logic       wdog_kick = 1'b0;
  logic       wdog_fired;
`endif

  int total = 0;
  int bad   = 0;
  int e     = 0;

  always #5 clk = ~clk;

  rst_seq #(
    .NUM_STAGES   (3),
    .STAGE_DLY    (16),
    .SOFT_HOLD    (8),
    .WDOG_TIMEOUT (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .soft_rst_req (soft_rst_req),
`ifdef RST_SEQ_WDOG_EN
    .wdog_kick    (wdog_kick),
    .wdog_fired   (wdog_fired),
`endif
    .stage_rst_n  (stage_rst_n),
    .rst_done     (rst_done),
    .busy         (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  // Expected stage pattern when stage 0 releases at edge base (16 apart).
  function automatic logic [2:0] exp_stage(input int k, input int base);
    if (k >= base + 32) return 3'b111;
    if (k >= base + 16) return 3'b011;
    if (k >= base)      return 3'b001;
    return 3'b000;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) tick();
    total++;
    if (stage_rst_n !== 3'b000) begin
      bad++; $display("FAIL reset_stage: got %b expected %b", stage_rst_n, 3'b000);
    end
    total++;
    if (rst_done !== 1'b0) begin
      bad++; $display("FAIL reset_done: got %b expected 0", rst_done);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL reset_busy: got %b expected 1", busy);
    end
`ifdef RST_SEQ_WDOG_EN
    total++;
    if (wdog_fired !== 1'b0) begin
      bad++; $display("FAIL reset_wdog_fired: got %b expected 0", wdog_fired);
    end
`endif
    rst_n = 1'b1;
    e = -1;
  endtask

  task automatic test_release();
    for (int k = 0; k <= 60; k++) begin
      tick();
      total++;
      if (stage_rst_n !== exp_stage(e, 16)) begin
        bad++; $display("FAIL release_stage e=%0d: got %b expected %b", e, stage_rst_n, exp_stage(e, 16));
      end
      total++;
      if (rst_done !== (e >= 48)) begin
        bad++; $display("FAIL release_done e=%0d: got %b expected %b", e, rst_done, (e >= 48));
      end
      total++;
      if (busy !== (e < 48)) begin
        bad++; $display("FAIL release_busy e=%0d: got %b expected %b", e, busy, (e < 48));
      end
    end
  endtask

  task automatic test_soft_pulse();
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    for (int k = 0; k <= 60; k++) begin
      if (k > 0) tick();
      total++;
      if (stage_rst_n !== exp_stage(k, 23)) begin
        bad++; $display("FAIL soft_pulse_stage S+%0d: got %b expected %b", k, stage_rst_n, exp_stage(k, 23));
      end
      total++;
      if (rst_done !== (k >= 55)) begin
        bad++; $display("FAIL soft_pulse_done S+%0d: got %b expected %b", k, rst_done, (k >= 55));
      end
      total++;
      if (busy !== (k < 55)) begin
        bad++; $display("FAIL soft_pulse_busy S+%0d: got %b expected %b", k, busy, (k < 55));
      end
    end
  endtask

  task automatic test_soft_hold();
    soft_rst_req = 1'b1;
    tick();
    for (int k = 0; k <= 70; k++) begin
      if (k > 0) tick();
      if (k == 19) soft_rst_req = 1'b0;
      total++;
      if (stage_rst_n !== exp_stage(k, 36)) begin
        bad++; $display("FAIL soft_hold_stage S+%0d: got %b expected %b", k, stage_rst_n, exp_stage(k, 36));
      end
      total++;
      if (rst_done !== (k >= 68)) begin
        bad++; $display("FAIL soft_hold_done S+%0d: got %b expected %b", k, rst_done, (k >= 68));
      end
    end
  endtask

  task automatic test_hard_abort();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    e = -1;
    while (e < 39) tick();
    total++;
    if (stage_rst_n !== 3'b011) begin
      bad++; $display("FAIL abort_pre_stage: got %b expected %b", stage_rst_n, 3'b011);
    end
    rst_n = 1'b0;
    tick();
    total++;
    if (stage_rst_n !== 3'b000) begin
      bad++; $display("FAIL abort_stage: got %b expected %b", stage_rst_n, 3'b000);
    end
    total++;
    if (rst_done !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL abort_done_busy: got done=%b busy=%b expected done=0 busy=1", rst_done, busy);
    end
    rst_n = 1'b1;
    e = -1;
    while (e < 16) begin
      tick();
      total++;
      if (stage_rst_n !== exp_stage(e, 16)) begin
        bad++; $display("FAIL abort_restart e=%0d: got %b expected %b", e, stage_rst_n, exp_stage(e, 16));
      end
    end
  endtask

  task automatic test_soft_in_release();
    while (e < 19) tick();
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    total++;
    if (stage_rst_n !== 3'b000 || busy !== 1'b1) begin
      bad++; $display("FAIL rel_abort_drop: got stage=%b busy=%b expected stage=000 busy=1", stage_rst_n, busy);
    end
    while (e < 76) begin
      tick();
      total++;
      if (stage_rst_n !== exp_stage(e, 43)) begin
        bad++; $display("FAIL rel_abort_stage e=%0d: got %b expected %b", e, stage_rst_n, exp_stage(e, 43));
      end
      total++;
      if (rst_done !== (e >= 75)) begin
        bad++; $display("FAIL rel_abort_done e=%0d: got %b expected %b", e, rst_done, (e >= 75));
      end
    end
  endtask

`ifdef RST_SEQ_WDOG_EN
  task automatic test_wdog();
    rst_n = 1'b0;
    wdog_kick = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    e = -1;
    while (e < 79) tick();
    total++;
    if (stage_rst_n !== 3'b111 || wdog_fired !== 1'b0) begin
      bad++; $display("FAIL wdog_pre: got stage=%b fired=%b expected stage=111 fired=0", stage_rst_n, wdog_fired);
    end
    tick();
    total++;
    if (stage_rst_n !== 3'b000 || wdog_fired !== 1'b1 || rst_done !== 1'b0) begin
      bad++; $display("FAIL wdog_timeout: got stage=%b fired=%b done=%b expected 000/1/0", stage_rst_n, wdog_fired, rst_done);
    end
    while (e < 135) begin
      tick();
      total++;
      if (wdog_fired !== 1'b1) begin
        bad++; $display("FAIL wdog_sticky e=%0d: got %b expected 1", e, wdog_fired);
      end
      if (e == 134) begin
        total++;
        if (stage_rst_n !== 3'b011) begin
          bad++; $display("FAIL wdog_reseq_134: got %b expected %b", stage_rst_n, 3'b011);
        end
      end
    end
    total++;
    if (stage_rst_n !== 3'b111 || rst_done !== 1'b1) begin
      bad++; $display("FAIL wdog_reseq_done: got stage=%b done=%b expected 111/1", stage_rst_n, rst_done);
    end
    for (int k = 1; k <= 100; k++) begin
      wdog_kick = (k % 20 == 0);
      tick();
      total++;
      if (stage_rst_n !== 3'b111 || busy !== 1'b0) begin
        bad++; $display("FAIL wdog_kicked e=%0d: got stage=%b busy=%b expected 111/0", e, stage_rst_n, busy);
      end
    end
    wdog_kick = 1'b0;
    while (e < 266) tick();
    wdog_kick = 1'b1;
    tick();
    wdog_kick = 1'b0;
    total++;
    if (stage_rst_n !== 3'b111) begin
      bad++; $display("FAIL wdog_kick_wins: got %b expected %b", stage_rst_n, 3'b111);
    end
    while (e < 298) tick();
    total++;
    if (stage_rst_n !== 3'b111) begin
      bad++; $display("FAIL wdog_pre2: got %b expected %b", stage_rst_n, 3'b111);
    end
    tick();
    total++;
    if (stage_rst_n !== 3'b000) begin
      bad++; $display("FAIL wdog_timeout2: got %b expected %b", stage_rst_n, 3'b000);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_release();
    test_soft_pulse();
    test_soft_hold();
    test_hard_abort();
    test_soft_in_release();
`ifdef RST_SEQ_WDOG_EN
    test_wdog();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
# rst_seq

Staged reset sequencer. It consumes the synchronized global reset `rst_n` and releases a set of per-subsystem active-low resets one at a time, with a fixed delay between releases. It also supports a soft-reset request that re-asserts all stage resets and reruns the sequence. It sits directly downstream of the push-button reset synchronizer and feeds the reset inputs of the major datapath blocks.

## Interface
- `NUM_STAGES`, default 3: number of staged reset outputs, ≥1.
- `STAGE_DLY`, default 16: cycles between consecutive stage releases, ≥1.
- `SOFT_HOLD`, default 8: minimum cycles all stages stay in reset after a soft request, ≥1.
- `WDOG_TIMEOUT`, default 1024: watchdog timeout in cycles. Only used when `RST_SEQ_WDOG_EN` is defined.
- `clk` input 1: system clock. All logic is on posedge.
- `rst_n` input 1: global reset. Synchronous, active-low.
- `soft_rst_req` input 1: level soft-reset request.
- `stage_rst_n` output NUM_STAGES: per-stage active-low resets. Bit 0 is released first.
- `rst_done` output 1: high when all stages are released.
- `busy` output 1: high in any state other than RUN.
- `wdog_kick` input 1: watchdog service pulse. Present only with `RST_SEQ_WDOG_EN`.
- `wdog_fired` output 1: sticky watchdog-timeout flag. Present only with `RST_SEQ_WDOG_EN`.

## Operation
- FSM states, held in `rst_seq_pkg::state_t`:
  - RELEASE: counting toward the next stage release; stage index `idx`, delay counter `cnt`.
  - RUN: all stages released.
  - SOFT: all stages held in reset.
- Reset (`rst_n`=0 at a posedge):
  - state = RELEASE, `idx`=0, `cnt`=0.
  - `stage_rst_n` = all 0, `rst_done`=0, `busy`=1, `wdog_fired`=0.
- RELEASE:
  - `cnt` increments each cycle.
  - When `cnt`==STAGE_DLY-1: set `stage_rst_n[idx]`=1, clear `cnt`, increment `idx`.
  - On releasing stage NUM_STAGES-1, go to RUN and set `rst_done`=1 on the same edge.
- Release is cumulative: a released stage stays released until the next soft or hard reset.
- `soft_rst_req`=1 sampled in RELEASE or RUN:
  - On that edge: all `stage_rst_n`=0, `rst_done`=0, `cnt`=0, go to SOFT.
  - An in-progress sequence is aborted.
- SOFT:
  - `cnt` counts up to SOFT_HOLD-1 and saturates there.
  - Leave SOFT on the first edge where `cnt`==SOFT_HOLD-1 and `soft_rst_req`=0. Go to RELEASE with `idx`=0, `cnt`=0.
  - A request held high keeps the block in SOFT indefinitely.
- `soft_rst_req` sampled in SOFT is ignored apart from the exit condition.
- `rst_n` low overrides everything, including in the middle of SOFT or RELEASE.
- Counter widths: `$clog2` of the largest of STAGE_DLY, SOFT_HOLD and WDOG_TIMEOUT, plus 1. No wrap-around is reachable.

## Timing
- All outputs are registered. Nothing is combinational from an input to an output.
- Edge 0 is the first posedge that samples `rst_n`=1.
- `stage_rst_n[k]` rises at edge (k+1)·STAGE_DLY. With defaults, stages release at edges 16, 32 and 48.
- `rst_done` rises at edge NUM_STAGES·STAGE_DLY.
- Soft request sampled at edge S:
  - Stages are low after S.
  - If the request drops before S+SOFT_HOLD-1, RELEASE begins at S+SOFT_HOLD-1 (call this edge R).
  - Stage 0 releases at edge R+STAGE_DLY.
- Minimum soft-reset pulse width on every stage is SOFT_HOLD+STAGE_DLY-1 cycles.

## Configuration
- `RST_SEQ_WDOG_EN` defined:
  - A watchdog counter runs in RUN only. It is cleared when not in RUN and on `wdog_kick`=1.
  - When it reaches WDOG_TIMEOUT-1 with no kick, the block behaves exactly as a sampled `soft_rst_req` for that cycle.
  - On timeout, `wdog_fired` is set. It is cleared only by `rst_n`.
  - If a kick and the timeout land on the same cycle, the kick wins.
- Undefined: `wdog_kick`, `wdog_fired` and the counter are absent. The sequencer is otherwise identical.

## Structure
- `rst_seq_pkg` holds:
  - `state_t` enum (RELEASE, RUN, SOFT);
  - the counter-width function;
  - default parameter constants.
- One sub-module, `rst_seq_cnt`: a clearable up-counter with terminal-count compare. It is instantiated for the stage/hold delay and, under the macro, for the watchdog.
- Elaboration-time assertion: NUM_STAGES, STAGE_DLY and SOFT_HOLD are all ≥1.

## Test plan
- Defaults, `rst_n` low for 5 cycles then high → `stage_rst_n` goes 3'b001 at edge 16, 3'b011 at 32, 3'b111 at 48; `rst_done`=1 at 48; `busy`=0 after 48.
- `soft_rst_req` 1-cycle pulse in RUN at edge S → `stage_rst_n`=0 after S; stage 0 re-releases at S+7+16; `rst_done` at S+7+48.
- `soft_rst_req` held 20 cycles → remains in SOFT until the request drops; stage 0 releases 16 cycles after exit.
- `rst_n` pulled low at edge 40 (stage 1 released) → all outputs 0 next edge; full sequence restarts from edge 0.
- `soft_rst_req` at edge 20 during RELEASE → stage 0 drops; sequence aborts and restarts after SOFT_HOLD.
- `RST_SEQ_WDOG_EN`, WDOG_TIMEOUT=32, no kicks in RUN → soft reset at edge 31 of RUN; `wdog_fired`=1 and stays 1 through the resequence. With a kick every 20 cycles → no timeout.
